icache_fetch: RTL and testbench
===============================

// Module: icache_fetch
// PURPOSE
// Direct-mapped, one-word-per-line instruction cache between the IF stage and the byte-wide memory controller.
// Serves if_addr lookups combinationally on a hit. On a miss it refills the line by issuing four byte reads
// to memory and raises stallreq_if to the stall controller until the word is present.
// A pending invalidate (fence.i) clears all lines.
// PARAMETERS
// INDEX_BITS  7   line index width; the cache holds 2**INDEX_BITS 32-bit lines
// ADDR_W      32  byte address width; tag = if_addr[ADDR_W-1:INDEX_BITS+2]
// PORTS
// clk           in   1       clock, all state on rising edge
// rst           in   1       asynchronous, active-low reset
// if_req        in   1       IF stage requests instruction at if_addr; addr held stable while stallreq_if=1
// if_addr       in   ADDR_W  instruction byte address; bits [1:0] ignored
// inv_req       in   1       one-cycle pulse: invalidate every line
// inst_valid    out  1       inst holds the word for if_addr this cycle
// inst          out  32      instruction word, little-endian assembled
// stallreq_if   out  1       stall request to the pipeline stall controller
// mem_req       out  1       byte read request; held with mem_addr until accepted
// mem_addr      out  ADDR_W  byte address of the request
// mem_gnt       in   1       request accepted this cycle when mem_req & mem_gnt
// mem_rvalid    in   1       a read byte is returned; responses in request order, latency >=1
// mem_rdata     in   8       returned byte
// BEHAVIOUR
// - Reset (rst=0, async): all valid bits 0, state IDLE, issue/response counters 0, inv_pend 0.
//   Reset also forces mem_req=0, mem_addr=0, inst_valid=0, inst=0 and stallreq_if=0.
// - Hit: if_req=1 & state IDLE & valid[idx] & tag match.
//   inst_valid=1 and inst=data[idx] in the same cycle (combinational); stallreq_if=0.
// - stallreq_if = if_req & ~hit. Asserted on the miss cycle and every refill cycle.
//   stallreq_if is never asserted when if_req=0.
// - States:
//   - IDLE: on if_req & miss, latch line address (if_addr[ADDR_W-1:2]) and go to FILL.
//   - FILL: issues bytes at offsets 0..3 of the latched word. mem_req=1 while issue_cnt<4.
//     mem_addr = {latched, issue_cnt[1:0]}; issue_cnt increments only on mem_req & mem_gnt.
//     Each mem_rvalid writes mem_rdata into byte rsp_cnt of the fill buffer and increments rsp_cnt.
//     When the 4th byte arrives: write the line to data/tag, set valid=~(inv_pend|inv_req), return to IDLE.
//   - Next cycle in IDLE, the held if_addr hits and stallreq_if drops.
// - Miss penalty with 1-cycle memory latency and mem_gnt=1: 6 cycles from the miss cycle to the first
//   cycle with stallreq_if=0.
// - mem_gnt=0: mem_req and mem_addr held unchanged; no counter advance.
// - mem_rvalid when no response is outstanding (IDLE): ignored. Simulation assertion fires.
// - if_addr changing during FILL (redirect): the refill still completes and the line is written for the
//   latched address. The new address is then looked up in IDLE and may miss again.
// - inv_req in IDLE: all valid bits clear at the next edge. A hit in that same cycle still returns data.
// - inv_req during FILL: sets inv_pend. On completion, valid bits are cleared and the refilled line stays
//   invalid, so the pending fetch misses and refetches; inv_pend then clears.
// - if_req=0 in IDLE: no lookup side effects. inst_valid=0; inst is don't-care.
// - Reset mid-FILL: abandons the refill with no line written. The memory controller shares rst and drops
//   its outstanding responses.
// - Arithmetic: issue_cnt and rsp_cnt are 3-bit, saturating at 4; index/tag are pure bit slices.
// TESTING
// - Cold miss: reset, if_req=1 if_addr=0x0000_0100, memory bytes 13,05,00,00.
//   -> 4 reads at 0x100..0x103, inst=0x0000_0513, inst_valid=1, stall high exactly 6 cycles.
// - Rehit: re-request 0x100 -> inst_valid=1 same cycle, stallreq_if=0, no mem_req.
// - Conflict: 0x100 then 0x300 (same index 0x40, INDEX_BITS=7).
//   -> 0x300 misses and refills; a later 0x100 misses again.
// - Backpressure: mem_gnt low for 3 cycles mid-issue.
//   -> mem_addr stable during the low cycles, correct word, penalty grows by 3.
// - Invalidate: hit at 0x100, pulse inv_req -> next 0x100 misses.
//   inv_req during a FILL of 0x200 -> 0x200 refetched twice.
// - Reset mid-FILL after 2 bytes: -> mem_req=0, stallreq_if=0 at once; later 0x104 lookup misses cleanly.

Source files
------------

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// A hit is served combinationally. A miss refills the line with four byte reads
// from the byte-wide memory controller and stalls the IF stage until the word is present.
module icache_fetch #(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              inv_req,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic              stallreq_if,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;
  localparam int LINE_W = ADDR_W - 2;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [2:0]          issue_cnt_q, issue_cnt_d;
  logic [2:0]          rsp_cnt_q, rsp_cnt_d;
  logic                inv_pend_q, inv_pend_d;
  logic [23:0]         fbuf_q, fbuf_d;
  logic [LINES-1:0]    valid_q, valid_d;

  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit;
  logic                  wr_en;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_W-1:0]      wr_tag;
  logic [31:0]           wr_data;

  // Byte offset bits of the fetch address play no part in the lookup.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^if_addr[1:0];

  assign idx     = if_addr[INDEX_BITS+1:2];
  assign tag     = if_addr[ADDR_W-1:INDEX_BITS+2];
  assign wr_idx  = line_q[INDEX_BITS-1:0];
  assign wr_tag  = line_q[LINE_W-1:INDEX_BITS];
  assign wr_data = {mem_rdata, fbuf_q};

  // Lookup and IF-side outputs; stall is gated by reset so it drops the moment reset asserts.
  always_comb begin
    hit         = if_req && (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == tag);
    inst_valid  = hit;
    inst        = hit ? data_q[idx] : 32'h0;
    stallreq_if = rst && if_req && !hit;
  end

  // Refill sequencing: issue four byte reads, collect four in-order responses, then write the line.
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    issue_cnt_d = issue_cnt_q;
    rsp_cnt_d   = rsp_cnt_q;
    inv_pend_d  = inv_pend_q;
    fbuf_d      = fbuf_q;
    valid_d     = valid_q;
    mem_req     = 1'b0;
    mem_addr    = '0;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (inv_req) valid_d = '0;
        if (if_req && !hit) begin
          line_d      = if_addr[ADDR_W-1:2];
          issue_cnt_d = 3'd0;
          rsp_cnt_d   = 3'd0;
          inv_pend_d  = 1'b0;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (inv_req) inv_pend_d = 1'b1;
        mem_req  = !issue_cnt_q[2];
        mem_addr = {line_q, issue_cnt_q[1:0]};
        if (mem_req && mem_gnt) issue_cnt_d = issue_cnt_q + 3'd1;
        if (mem_rvalid && !rsp_cnt_q[2]) begin
          rsp_cnt_d = rsp_cnt_q + 3'd1;
          case (rsp_cnt_q[1:0])
            2'd0: fbuf_d[7:0]   = mem_rdata;
            2'd1: fbuf_d[15:8]  = mem_rdata;
            2'd2: fbuf_d[23:16] = mem_rdata;
            default: begin
              // Last byte: commit the line; an invalidate seen during the refill wipes it too.
              wr_en = 1'b1;
              if (inv_pend_q || inv_req) valid_d = '0;
              else valid_d[wr_idx] = 1'b1;
              inv_pend_d  = 1'b0;
              issue_cnt_d = 3'd0;
              rsp_cnt_d   = 3'd0;
              state_d     = IDLE;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      line_q      <= '0;
      issue_cnt_q <= 3'd0;
      rsp_cnt_q   <= 3'd0;
      inv_pend_q  <= 1'b0;
      fbuf_q      <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      issue_cnt_q <= issue_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
      inv_pend_q  <= inv_pend_d;
      fbuf_q      <= fbuf_d;
      valid_q     <= valid_d;
    end
  end

  // Tag and data storage; contents are qualified by valid_q so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_idx] <= wr_data;
      tag_q[wr_idx]  <= wr_tag;
    end
  end

  // A returned byte with no refill in progress means the memory side is out of step.
  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!rst)
    !(mem_rvalid && (state_q == IDLE)));

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: directed vector table, multi-cycle corner
// sequences, and randomized fetch traffic against a line-presence model.
module tb_icache_fetch;
  localparam int IB = 7;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          inv_req = 1'b0;
  logic          mem_gnt = 1'b1;
  logic          mem_rvalid = 1'b0;
  logic [7:0]    mem_rdata = '0;
  logic          inst_valid, stallreq_if, mem_req;
  logic [31:0]   inst;
  logic [AW-1:0] mem_addr;

  int total = 0;
  int bad = 0;
  bit rand_gnt = 1'b0;
  bit rand_lat = 1'b0;
  logic [AW-1:0] pend[$];
  logic [AW-1:0] gaddr[$];
  logic [29:0]   mline[int];

  typedef struct {
    logic [31:0] addr;
    int          exp_stall;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  icache_fetch #(.INDEX_BITS(IB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .inv_req(inv_req),
    .inst_valid(inst_valid), .inst(inst), .stallreq_if(stallreq_if),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102: return 8'h00;
      32'h103: return 8'h00;
      default: return (a[7:0] * 8'd29) ^ a[15:8] ^ 8'h5a;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return {byte_at(w + 3), byte_at(w + 2), byte_at(w + 1), byte_at(w)};
  endfunction

  // Byte-wide memory: grants queue up, responses come back in order one or more cycles later.
  always @(posedge clk) begin
    if (rst && mem_req && mem_gnt) pend.push_back(mem_addr);
    #1;
    if (!rst) begin
      pend.delete();
      mem_rvalid = 1'b0;
    end else if (pend.size() > 0 && (!rand_lat || $urandom_range(0, 2) != 0)) begin
      mem_rvalid = 1'b1;
      mem_rdata  = byte_at(pend.pop_front());
    end else begin
      mem_rvalid = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    if (rand_gnt) mem_gnt = ($urandom_range(0, 3) != 0);
    #1;
  endtask

  // Present a fetch and hold it until the stall drops; exact<0 checks only hit/miss against the model.
  task automatic fetch(input logic [31:0] a, input int exact, input string nm);
    int n;
    bit mh;
    int idx;
    idx = int'(a[8:2]);
    mh = mline.exists(idx) && (mline[idx] == a[31:2]);
    gaddr.delete();
    if_req = 1'b1;
    if_addr = a;
    #1;
    n = 0;
    if (!stallreq_if) chk({nm, " no mem_req on hit"}, 64'(mem_req), 64'd0);
    while (stallreq_if && n < 400) begin
      if (mem_req && mem_gnt) gaddr.push_back(mem_addr);
      cyc();
      n++;
    end
    if (n >= 400) chk({nm, " timeout"}, 64'd1, 64'd0);
    if (exact >= 0) chk({nm, " stall cycles"}, 64'(n), 64'(exact));
    else chk({nm, " hit"}, 64'(n == 0), 64'(mh));
    chk({nm, " inst_valid"}, 64'(inst_valid), 64'd1);
    chk({nm, " inst"}, 64'(inst), 64'(word_at(a)));
    mline[idx] = a[31:2];
  endtask

  // Refill with a scheduled grant-deny window and an optional invalidate pulse at a given cycle.
  task automatic fill_seq(input logic [31:0] a, input int dlo, input int dhi, input int inv_at,
                          output int ncyc, output int ngnt, output bit stable,
                          output logic [31:0] held);
    if_req = 1'b1;
    if_addr = a;
    mem_gnt = 1'b1;
    inv_req = 1'b0;
    #1;
    ncyc = 0;
    ngnt = 0;
    stable = 1'b1;
    held = '0;
    while (stallreq_if && ncyc < 400) begin
      if (mem_req && mem_gnt) ngnt++;
      if (ncyc == dlo) held = mem_addr;
      if (ncyc >= dlo && ncyc <= dhi && (!mem_req || mem_addr !== held)) stable = 1'b0;
      @(posedge clk);
      #2;
      mem_gnt = !((ncyc + 1) >= dlo && (ncyc + 1) <= dhi);
      inv_req = ((ncyc + 1) == inv_at);
      #1;
      ncyc++;
    end
    inv_req = 1'b0;
    mem_gnt = 1'b1;
  endtask

  initial begin
    int ncyc, ngnt;
    bit stable;
    logic [31:0] held;

    vecs[0] = '{32'h100, 6};
    vecs[1] = '{32'h100, 0};
    vecs[2] = '{32'h300, 6};
    vecs[3] = '{32'h100, 6};
    vecs[4] = '{32'h104, 6};
    vecs[5] = '{32'h103, 0};
    vecs[6] = '{32'h104, 0};
    vecs[7] = '{32'h300, 6};
    vecs[8] = '{32'h100, 6};

    // Reset state with a request already pending.
    if_req = 1'b1;
    if_addr = 32'h100;
    #3;
    chk("rst inst_valid", 64'(inst_valid), 64'd0);
    chk("rst inst", 64'(inst), 64'd0);
    chk("rst stallreq_if", 64'(stallreq_if), 64'd0);
    chk("rst mem_req", 64'(mem_req), 64'd0);
    chk("rst mem_addr", 64'(mem_addr), 64'd0);
    cyc();
    cyc();
    rst = 1'b1;

    // Vector table: cold miss, rehit, conflicts on index 0x40, offset bits ignored.
    for (int i = 0; i < 9; i++) begin
      fetch(vecs[i].addr, vecs[i].exp_stall, $sformatf("vec%0d", i));
      if (i == 0) begin
        chk("cold word", 64'(inst), 64'h0000_0513);
        chk("cold nreads", 64'(gaddr.size()), 64'd4);
        for (int j = 0; j < 4 && j < gaddr.size(); j++)
          chk($sformatf("cold read%0d addr", j), 64'(gaddr[j]), 64'(32'h100 + j));
      end
    end

    // Invalidate in IDLE while hitting: data still returned that cycle, next lookup misses.
    if_req = 1'b1;
    if_addr = 32'h100;
    inv_req = 1'b1;
    #1;
    chk("inv idle same-cycle valid", 64'(inst_valid), 64'd1);
    chk("inv idle same-cycle inst", 64'(inst), 64'(word_at(32'h100)));
    cyc();
    inv_req = 1'b0;
    mline.delete();
    fetch(32'h100, 6, "after inv");

    // Backpressure: three denied grants after the second byte.
    fill_seq(32'h208, 3, 5, -1, ncyc, ngnt, stable, held);
    chk("bp stall cycles", 64'(ncyc), 64'd9);
    chk("bp grants", 64'(ngnt), 64'd4);
    chk("bp addr stable", 64'(stable), 64'd1);
    chk("bp held addr", 64'(held), 64'h20a);
    chk("bp inst", 64'(inst), 64'(word_at(32'h208)));
    mline[int'(8'h82 & 8'h7f)] = 30'(32'h208 >> 2);

    // Invalidate during a refill: the line is fetched twice.
    fill_seq(32'h200, -1, -1, 2, ncyc, ngnt, stable, held);
    chk("inv fill stall cycles", 64'(ncyc), 64'd12);
    chk("inv fill grants", 64'(ngnt), 64'd8);
    chk("inv fill inst_valid", 64'(inst_valid), 64'd1);
    chk("inv fill inst", 64'(inst), 64'(word_at(32'h200)));
    mline.delete();
    mline[0] = 30'(32'h200 >> 2);

    // Redirect mid-refill: old line still lands, new address then misses on its own.
    if_req = 1'b1;
    if_addr = 32'h400;
    #1;
    cyc();
    cyc();
    mline[0] = 30'(32'h400 >> 2);
    fetch(32'h108, -1, "redirect new");
    fetch(32'h400, 0, "redirect old");

    // Reset after two bytes of a refill.
    if_req = 1'b1;
    if_addr = 32'h600;
    #1;
    chk("midfill pre stall", 64'(stallreq_if), 64'd1);
    for (int k = 0; k < 4; k++) cyc();
    rst = 1'b0;
    #1;
    chk("midfill rst mem_req", 64'(mem_req), 64'd0);
    chk("midfill rst stall", 64'(stallreq_if), 64'd0);
    chk("midfill rst inst_valid", 64'(inst_valid), 64'd0);
    cyc();
    cyc();
    rst = 1'b1;
    mline.delete();
    fetch(32'h104, 6, "post rst 0x104");
    chk("post rst first read", 64'(gaddr.size() > 0 ? gaddr[0] : 32'hffff_ffff), 64'h104);
    fetch(32'h600, 6, "post rst 0x600");

    // Randomized traffic: a few conflicting indices, random grants and response latency.
    rand_gnt = 1'b1;
    rand_lat = 1'b1;
    for (int k = 0; k < 150; k++) begin
      logic [31:0] a;
      int r;
      int ic;
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0: ic = 0;
        1: ic = 1;
        2: ic = 8'h40;
        default: ic = 8'h41;
      endcase
      a = (32'($urandom_range(0, 3)) << 9) | (32'(ic) << 2) | 32'($urandom_range(0, 3));
      if (r == 0) begin
        if_req = 1'b0;
        inv_req = 1'b1;
        #1;
        chk("rnd inv stall", 64'(stallreq_if), 64'd0);
        cyc();
        inv_req = 1'b0;
        mline.delete();
      end else if (r == 1) begin
        if_req = 1'b0;
        if_addr = $urandom;
        #1;
        chk("rnd idle stall", 64'(stallreq_if), 64'd0);
        chk("rnd idle inst_valid", 64'(inst_valid), 64'd0);
        cyc();
      end else begin
        fetch(a, -1, "rnd");
      end
    end
    rand_gnt = 1'b0;
    rand_lat = 1'b0;
    mem_gnt = 1'b1;
    if_req = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
